ram_page_reader: RTL and testbench
==================================

// Module: ram_page_reader
// PURPOSE
//  Sequential reader for the 8-bit page buffer RAM. It is the read-side counterpart of the RAM clear/fill path.
//  On start_rd it walks addresses 0..PAGE_LEN-1 and drives the RAM read port.
//  Read data is captured into a small output FIFO, then streamed on a valid/ready byte interface.
//  The consumer is the NAND program data path. end_rd marks page completion.
// PARAMETERS
//  ADDR_W      15     RAM address width
//  DATA_W      8      RAM / stream data width
//  PAGE_LEN    16384  bytes per page read; 1 <= PAGE_LEN <= 2**ADDR_W-1
//  FIFO_DEPTH  4      output FIFO entries; power of 2, >= 3 for full throughput
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  start_rd     in   1       start page read; sampled only in IDLE
//  ram_change   in   1       buffer swap / abort; same effect as rst on this block
//  en_ram_rd    out  1       RAM enable (read, we=0)
//  address_rd   out  ADDR_W  RAM read address
//  ram_data_in  in   DATA_W  RAM read data; valid the cycle after en_ram_rd
//  dout         out  DATA_W  stream byte (FIFO head)
//  dout_valid   out  1       dout holds a byte
//  dout_ready   in   1       consumer accepts; transfer = dout_valid & dout_ready
//  dout_last    out  1       high with the final byte (index PAGE_LEN-1)
//  busy         out  1       state != IDLE
//  end_rd       out  1       1-cycle pulse: whole page transferred
// BEHAVIOUR
//  Reset: one clock; sync active-high rst. rst or ram_change at a clock edge gives:
//   - state IDLE, issue count 0, FIFO empty, in-flight flag 0
//   - outputs: en_ram_rd=0, address_rd=0, dout_valid=0, dout_last=0, busy=0, end_rd=0, dout=0
//   - Takes effect mid-page; RAM data already in flight is discarded.
//  FSM: IDLE -> READ on start_rd. READ -> DONE on the edge the last byte transfers. DONE -> IDLE after 1 cycle.
//   - end_rd = (state==DONE).
//   - start_rd is ignored in READ and DONE.
//  Issue rule (combinational from registers):
//   - en_ram_rd = READ & issued<PAGE_LEN & (occupancy+inflight)<FIFO_DEPTH
//   - occupancy is the registered count; a pop in the same cycle gives no credit.
//   - address_rd = issued (ADDR_W bits); issued increments on each issue. No wrap; issue stops at PAGE_LEN.
//  Capture: inflight<=en_ram_rd each edge. When inflight=1, ram_data_in is pushed into the FIFO that edge.
//   - Push and pop may occur on the same edge.
//   - The credit rule guarantees the FIFO never overflows.
//  Output: dout_valid = occupancy!=0, dout = FIFO head.
//   - dout_last tracks a transfer counter; it is high when the head is byte PAGE_LEN-1.
//   - dout and dout_valid are stable while dout_valid & !dout_ready.
//  Latency: start_rd high in cycle 0 gives:
//   - cycle 1: en_ram_rd=1, addr 0
//   - cycle 2: RAM data returns
//   - cycle 3: dout_valid
//   - With dout_ready held 1: 1 byte/cycle, last byte in cycle PAGE_LEN+2, end_rd in cycle PAGE_LEN+3.
//  PAGE_LEN=1: single issue; dout_last is asserted on the first byte.
// TESTING (RAM model: sync read, 1-cycle latency, mem[a]=a[7:0])
//  1 PAGE_LEN=16, ready=1, start_rd cycle 0 -> en_ram_rd cycles 1..16, addr 0..15; dout 0x00..0x0F in cycles 3..18;
//    dout_last cycle 18; end_rd cycle 19; busy=0 from cycle 20.
//  2 ready=0 cycles 3..10 -> issues addr 0..3 (cycles 1..4), en_ram_rd=0 cycles 5..10, dout=0x00 held;
//    after ready returns, 16 bytes in order, no loss/duplication.
//  3 ready toggles 1/0 every cycle, PAGE_LEN=16 -> 16 transfers in order; occupancy never exceeds 4.
//  4 ram_change in cycle 8 mid-page -> cycle 9: busy=0, dout_valid=0, address_rd=0, no end_rd;
//    restart gives dout 0x00 first.
//  5 start_rd held high during READ and DONE -> no restart; a single end_rd pulse; new page only after IDLE.
//  6 rst asserted in cycle 5 with start_rd=1 -> all outputs at reset values in cycle 6;
//    start_rd sampled at the edge rst deasserts.

Source files
------------

// File: rtl/ram_page_reader_if.sv
// ---------------------------------------------------------------------------
// ram_page_reader_if
// Groups every non-clock/reset signal of the page reader.
//   control : start_rd (start a page), ram_change (buffer swap / abort)
//   RAM     : en_ram_rd, address_rd, ram_data_in (sync read, 1-cycle latency)
//   stream  : dout, dout_valid, dout_ready, dout_last
//   status  : busy, end_rd
// Modports:
//   master : the reader itself (drives RAM port, stream and status)
//   slave  : the environment (controller, RAM and stream consumer)
// ---------------------------------------------------------------------------
interface ram_page_reader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              start_rd;
  logic              ram_change;
  logic              en_ram_rd;
  logic [ADDR_W-1:0] address_rd;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              busy;
  logic              end_rd;

  modport master (
    input  start_rd, ram_change, ram_data_in, dout_ready,
    output en_ram_rd, address_rd, dout, dout_valid, dout_last, busy, end_rd
  );

  modport slave (
    output start_rd, ram_change, ram_data_in, dout_ready,
    input  en_ram_rd, address_rd, dout, dout_valid, dout_last, busy, end_rd
  );
endinterface

// File: rtl/ram_page_reader.sv
// ---------------------------------------------------------------------------
// ram_page_reader
// Sequential reader for the 8-bit page buffer RAM. On start_rd it walks
// addresses 0..PAGE_LEN-1, captures the read data into a small FIFO and
// streams it out on a valid/ready byte interface. end_rd pulses once when
// the last byte has been accepted.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ram_page_reader_if.master (control, RAM read port, stream, status)
// rst and ram_change have the same effect: back to IDLE, FIFO emptied and
// any RAM read in flight dropped.
// ---------------------------------------------------------------------------
module ram_page_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int PAGE_LEN   = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  ram_page_reader_if.master  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] PAGE_LEN_C = ADDR_W'(PAGE_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX_C = ADDR_W'(PAGE_LEN - 1);
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_issued;
  logic [ADDR_W-1:0]   r_xfer;
  logic                r_inflight;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_clear;
  logic [CNT_W:0]      w_credit;
  logic                w_issue;
  logic                w_push;
  logic                w_valid;
  logic                w_pop;
  logic                w_last;

  // Datapath decode: issue credit, FIFO handshake and last-byte detect.
  always_comb begin
    w_clear  = rst | bus.ram_change;
    // Registered occupancy only: a pop this cycle does not free a slot yet.
    w_credit = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    w_issue  = (r_state == S_READ) && (r_issued < PAGE_LEN_C) && (w_credit < DEPTH_C);
    w_push   = r_inflight;
    w_valid  = (r_count != {CNT_W{1'b0}});
    w_pop    = w_valid && bus.dout_ready;
    w_last   = w_valid && (r_xfer == LAST_IDX_C);
  end

  // FSM next state: page ends on the edge the final byte transfers.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_rd) begin
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_pop && w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue and transfer counters; cleared in DONE so IDLE shows address 0.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_issued   <= {ADDR_W{1'b0}};
      r_xfer     <= {ADDR_W{1'b0}};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == S_DONE) begin
        r_issued <= {ADDR_W{1'b0}};
        r_xfer   <= {ADDR_W{1'b0}};
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (w_pop) begin
          r_xfer <= r_xfer + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while not valid, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !w_clear) begin
      r_mem[r_wr_ptr] <= bus.ram_data_in;
    end
  end

  // Outputs are decoded from registers only.
  always_comb begin
    bus.en_ram_rd  = w_issue;
    bus.address_rd = r_issued;
    bus.dout_valid = w_valid;
    // Gate the head so dout reads zero whenever the FIFO is empty.
    if (w_valid) begin
      bus.dout = r_mem[r_rd_ptr];
    end else begin
      bus.dout = {DATA_W{1'b0}};
    end
    bus.dout_last  = w_last;
    bus.busy       = (r_state != S_IDLE);
    bus.end_rd     = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_ram_page_reader.sv
module tb_ram_page_reader;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;
  localparam int PAGE_LEN = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ram_page_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_page_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAGE_LEN(PAGE_LEN), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read, 1-cycle latency, mem[a] = a[7:0]
  always @(posedge clk) begin
    if (bus.en_ram_rd) bus.ram_data_in <= bus.address_rd[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    bus.en_ram_rd, 0);
    check({tag, "_addr"},  bus.address_rd, 0);
    check({tag, "_valid"}, bus.dout_valid, 0);
    check({tag, "_last"},  bus.dout_last, 0);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_end"},   bus.end_rd, 0);
    check({tag, "_dout"},  bus.dout, 0);
  endtask

  // Start pulse in cycle 0; returns in cycle 1.
  task automatic start_page();
    bus.start_rd = 1'b1;
    tick();
    bus.start_rd = 1'b0;
  endtask

  // Drain a page: mode 0 ready always high, mode 1 ready toggles.
  // Checks byte order, dout_last and a single end_rd; returns in the DONE cycle.
  task automatic drain(input string tag, input int mode);
    int  idx = 0;
    int  budget = 0;
    bit  done = 1'b0;
    while (!done && budget < 400) begin
      bus.dout_ready = (mode == 0) ? 1'b1 : ((budget % 2) == 0);
      if (bus.end_rd) begin
        done = 1'b1;
      end else begin
        if (bus.dout_valid && bus.dout_ready) begin
          check({tag, "_byte"}, bus.dout, idx & 32'hFF);
          check({tag, "_last"}, bus.dout_last, (idx == PAGE_LEN - 1));
          idx++;
        end
        tick();
        budget++;
      end
    end
    check({tag, "_count"}, idx, PAGE_LEN);
    check({tag, "_end_seen"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    bus.start_rd   = 1'b0;
    bus.ram_change = 1'b0;
    bus.dout_ready = 1'b1;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: nominal page, ready held high
    start_page();
    for (int c = 1; c <= 20; c++) begin
      check("t1_en", bus.en_ram_rd, (c <= 16));
      if (c <= 16) check("t1_addr", bus.address_rd, c - 1);
      check("t1_valid", bus.dout_valid, (c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) check("t1_dout", bus.dout, c - 3);
      check("t1_last", bus.dout_last, (c == 18));
      check("t1_end", bus.end_rd, (c == 19));
      check("t1_busy", bus.busy, (c <= 19));
      tick();
    end

    // 2: consumer stalls cycles 3..10
    bus.dout_ready = 1'b0;
    start_page();
    for (int c = 1; c <= 10; c++) begin
      check("t2_en", bus.en_ram_rd, (c <= 4));
      if (c <= 4) check("t2_addr", bus.address_rd, c - 1);
      if (c >= 3) begin
        check("t2_valid", bus.dout_valid, 1);
        check("t2_dout", bus.dout, 0);
      end
      tick();
    end
    drain("t2", 0);
    tick(); tick();

    // 3: ready toggling every cycle
    start_page();
    drain("t3", 1);
    tick(); tick();
    bus.dout_ready = 1'b1;

    // 4: ram_change in cycle 8 aborts the page
    start_page();
    for (int c = 1; c < 8; c++) tick();
    bus.ram_change = 1'b1;
    tick();
    bus.ram_change = 1'b0;
    check("t4_busy", bus.busy, 0);
    check("t4_valid", bus.dout_valid, 0);
    check("t4_addr", bus.address_rd, 0);
    check("t4_en", bus.en_ram_rd, 0);
    for (int c = 0; c < 5; c++) begin
      check("t4_no_end", bus.end_rd, 0);
      tick();
    end
    start_page();
    tick(); tick();
    check("t4_restart_valid", bus.dout_valid, 1);
    check("t4_restart_dout", bus.dout, 0);
    drain("t4r", 0);
    tick(); tick();

    // 5: start_rd held high through READ and DONE
    bus.start_rd = 1'b1;
    tick();
    drain("t5", 0);
    tick();
    check("t5_idle_busy", bus.busy, 0);
    check("t5_idle_end", bus.end_rd, 0);
    tick();
    check("t5_restart_busy", bus.busy, 1);
    check("t5_restart_en", bus.en_ram_rd, 1);
    check("t5_restart_addr", bus.address_rd, 0);
    bus.start_rd = 1'b0;
    drain("t5b", 0);
    tick(); tick();

    // 6: rst in cycle 5 with start_rd held high
    start_page();
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    bus.start_rd = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    tick();
    check("t6_busy", bus.busy, 1);
    check("t6_en", bus.en_ram_rd, 1);
    check("t6_addr", bus.address_rd, 0);
    bus.start_rd = 1'b0;
    drain("t6", 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
